// File: rtl/ctrl_pipe.sv
// Decoded-control pipeline: STAGES registered stages behind decode with per-stage
// stall/flush, backward stall propagation and a multi-cycle (mul/div) busy FSM on stage 0.
module ctrl_pipe_stage #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         hold,
    input  logic         bubble,
    input  logic         up_vld,
    input  logic [W-1:0] up_ctrl,
    output logic         vld_q,
    output logic [W-1:0] ctrl_q
);
    logic         vld_d;
    logic [W-1:0] ctrl_d;

    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        if (flush || (!hold && bubble)) begin
            vld_d  = 1'b0;
            ctrl_d = '0;
        end else if (!hold) begin
            vld_d  = up_vld;
            // an invalid slot always carries an all-zero bundle
            ctrl_d = up_vld ? up_ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
        end
    end
endmodule

module ctrl_pipe #(
    parameter int W         = 24,
    parameter int STAGES    = 3,
    parameter int MC_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          ctrl_in,
    input  logic                  valid_in,
    input  logic                  mc_start,
    input  logic [STAGES-1:0]     stall_in,
    input  logic [STAGES-1:0]     flush_in,
    output logic [W*STAGES-1:0]   ctrl_out,
    output logic [STAGES-1:0]     valid_out,
    output logic                  mc_busy,
    output logic                  mc_done,
    output logic                  stall_req
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] MC_INIT = 8'(MC_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       mc_busy_q, mc_done_q;
    logic [STAGES-1:0]          stall_eff;
    logic [STAGES-1:0]          vld_q;
    logic [STAGES-1:0][W-1:0]   ctrl_q;
    logic                       load0;

    // A stall at stage k freezes every younger stage; busy only blocks stage 0.
    always_comb begin
        stall_eff = '0;
        for (int k = 0; k < STAGES; k++)
            for (int j = k; j < STAGES; j++)
                if (stall_in[j]) stall_eff[k] = 1'b1;
        stall_eff[0] = stall_eff[0] | mc_busy_q;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         up_vld, bub;
        logic [W-1:0] up_ctrl;
        if (k == 0) begin : g_head
            assign up_vld  = valid_in;
            assign up_ctrl = ctrl_in;
            assign bub     = 1'b0;
        end else begin : g_body
            assign up_vld  = vld_q[k-1];
            assign up_ctrl = ctrl_q[k-1];
            assign bub     = stall_eff[k-1];
        end
        ctrl_pipe_stage #(.W(W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush_in[k]),
            .hold    (stall_eff[k]),
            .bubble  (bub),
            .up_vld  (up_vld),
            .up_ctrl (up_ctrl),
            .vld_q   (vld_q[k]),
            .ctrl_q  (ctrl_q[k])
        );
    end

    assign load0 = !flush_in[0] && !stall_eff[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            BUSY: begin
                if (flush_in[0]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                // the instruction that starts the unit is the one entering stage 0
                if (load0 && valid_in && mc_start) begin
                    state_d = BUSY;
                    cnt_d   = MC_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mc_busy_q <= 1'b0;
            mc_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mc_busy_q <= (state_d == BUSY);
            mc_done_q <= (state_d == DONE);
        end
    end

    assign ctrl_out  = ctrl_q;
    assign valid_out = vld_q;
    assign mc_busy   = mc_busy_q;
    assign mc_done   = mc_done_q;
    assign stall_req = mc_busy_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized + directed bench for ctrl_pipe (W=8, STAGES=3, MC_CYCLES=4) against a
// slot-level pipeline model that tracks remaining busy cycles instead of FSM states.
module tb_ctrl_pipe;
    localparam int W = 8, ST = 3, MC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    ctrl_in;
    logic            valid_in, mc_start;
    logic [ST-1:0]   stall_in, flush_in;
    logic [W*ST-1:0] ctrl_out;
    logic [ST-1:0]   valid_out;
    logic            mc_busy, mc_done, stall_req;

    ctrl_pipe #(.W(W), .STAGES(ST), .MC_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .valid_in(valid_in), .mc_start(mc_start),
        .stall_in(stall_in), .flush_in(flush_in), .ctrl_out(ctrl_out), .valid_out(valid_out),
        .mc_busy(mc_busy), .mc_done(mc_done), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]      v;
        logic [2:0][7:0] c;
        logic [8:0]      left;   // busy cycles still to run, 0 = not busy
        logic            done;
    } mdl_t;

    mdl_t m;
    int   checks = 0, errors = 0;

    function automatic mdl_t model_next(mdl_t cur, logic vi, logic [7:0] ci, logic ms,
                                        logic [2:0] st, logic [2:0] fl);
        mdl_t       n;
        logic [2:0] s;
        logic       busy;
        n    = cur;
        busy = (cur.left != 0);
        for (int k = 0; k < 3; k++) begin
            s[k] = 1'b0;
            for (int j = k; j < 3; j++) s[k] = s[k] | st[j];
        end
        s[0] = s[0] | busy;
        for (int k = 0; k < 3; k++) begin
            if (fl[k]) begin
                n.v[k] = 1'b0; n.c[k] = 8'h00;
            end else if (s[k]) begin
                n.v[k] = cur.v[k]; n.c[k] = cur.c[k];
            end else if (k == 0) begin
                n.v[0] = vi; n.c[0] = vi ? ci : 8'h00;
            end else if (s[k-1]) begin
                n.v[k] = 1'b0; n.c[k] = 8'h00;
            end else begin
                n.v[k] = cur.v[k-1]; n.c[k] = cur.c[k-1];
            end
        end
        n.done = 1'b0;
        if (busy) begin
            if (fl[0]) n.left = 9'd0;
            else begin
                n.left = cur.left - 9'd1;
                n.done = (cur.left == 9'd1);
            end
        end else if (!fl[0] && !s[0] && vi && ms) n.left = 9'(MC);
        else n.left = 9'd0;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("valid_out", 32'(valid_out), 32'(m.v));
        chk("ctrl_out", 32'(ctrl_out), 32'(m.c));
        chk("mc_busy", 32'(mc_busy), 32'(m.left != 0));
        chk("mc_done", 32'(mc_done), 32'(m.done));
        chk("stall_req", 32'(stall_req), 32'(m.left != 0));
    endtask

    task automatic drv(input logic v, input logic [7:0] c, input logic ms,
                       input logic [2:0] st, input logic [2:0] fl);
        valid_in = v; ctrl_in = c; mc_start = ms; stall_in = st; flush_in = fl;
    endtask

    // one clock: advance model, let DUT update, compare on the falling edge
    task automatic step();
        mdl_t nx;
        nx = model_next(m, valid_in, ctrl_in, mc_start, stall_in, flush_in);
        @(posedge clk);
        m = rst ? nx : '0;
        @(negedge clk);
        cmp_model();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 32'(valid_out), 32'h0);
        chk({nm, "_ctrl"}, 32'(ctrl_out), 32'h0);
        chk({nm, "_busy"}, 32'(mc_busy), 32'h0);
        chk({nm, "_done"}, 32'(mc_done), 32'h0);
        chk({nm, "_stallreq"}, 32'(stall_req), 32'h0);
    endtask

    task automatic drain();
        drv(1'b0, 8'h00, 1'b0, 3'b000, 3'b000);
        repeat (MC + 4) step();
    endtask

    initial begin
        rst = 1'b1;
        m   = '0;
        drv(1'b0, 8'h00, 1'b0, 3'b000, 3'b000);
        #1 rst = 1'b0;
        #2 chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // streaming
        drv(1'b1, 8'h11, 1'b0, 3'b000, 3'b000); step();
        chk("stream_c1", 32'(ctrl_out[7:0]), 32'h11);
        drv(1'b1, 8'h22, 1'b0, 3'b000, 3'b000); step();
        chk("stream_c2", 32'(ctrl_out[15:8]), 32'h11);
        drv(1'b1, 8'h33, 1'b0, 3'b000, 3'b000); step();
        chk("stream_c3", 32'(ctrl_out), 32'h112233);
        chk("stream_v3", 32'(valid_out), 32'h7);
        drain();

        // stall at stage 1
        drv(1'b1, 8'hA5, 1'b0, 3'b000, 3'b000); step();
        drv(1'b1, 8'hB6, 1'b0, 3'b000, 3'b000); step();
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 8'hC7, 1'b0, 3'b010, 3'b000); step();
            chk("stall_ctrl", 32'(ctrl_out), 32'h00A5B6);
            chk("stall_valid", 32'(valid_out), 32'h3);
        end
        drv(1'b1, 8'hC7, 1'b0, 3'b000, 3'b000); step();
        chk("stall_release", 32'(ctrl_out), 32'hA5B6C7);
        drain();

        // multi-cycle op
        drv(1'b1, 8'h5C, 1'b1, 3'b000, 3'b000); step();
        drv(1'b0, 8'h00, 1'b0, 3'b000, 3'b000);
        for (int i = 0; i < MC; i++) begin
            chk("mc_busy_on", 32'(mc_busy), 32'h1);
            chk("mc_hold", 32'(ctrl_out[7:0]), 32'h5C);
            chk("mc_bubble", 32'(valid_out[1]), 32'h0);
            step();
        end
        chk("mc_done_on", 32'({mc_busy, mc_done}), 32'h1);
        chk("mc_done_hold", 32'(ctrl_out), 32'h00005C);
        step();
        chk("mc_adv", 32'(ctrl_out), 32'h005C00);
        chk("mc_done_off", 32'(mc_done), 32'h0);
        drain();

        // abort with flush on 2nd busy cycle
        drv(1'b1, 8'h3D, 1'b1, 3'b000, 3'b000); step();
        drv(1'b0, 8'h00, 1'b0, 3'b000, 3'b000); step();
        drv(1'b0, 8'h00, 1'b0, 3'b000, 3'b001); step();
        chk("abort_s0", 32'({valid_out[0], ctrl_out[7:0]}), 32'h0);
        chk("abort_busy", 32'(mc_busy), 32'h0);
        drv(1'b0, 8'h00, 1'b0, 3'b000, 3'b000);
        for (int i = 0; i < MC + 2; i++) begin
            step();
            chk("abort_nodone", 32'(mc_done), 32'h0);
        end

        // stall during DONE holds stage 0 and does not restart
        drv(1'b1, 8'h9E, 1'b1, 3'b000, 3'b000); step();
        drv(1'b1, 8'h9E, 1'b1, 3'b000, 3'b000);
        repeat (MC) step();
        drv(1'b1, 8'h9E, 1'b1, 3'b001, 3'b000); step();
        chk("done_stall", 32'({mc_busy, mc_done, ctrl_out[7:0]}), 32'h09E);
        drain();

        // flush + stall on stage 2
        drv(1'b1, 8'h01, 1'b0, 3'b000, 3'b000); step();
        drv(1'b1, 8'h02, 1'b0, 3'b000, 3'b000); step();
        drv(1'b1, 8'h03, 1'b0, 3'b000, 3'b000); step();
        drv(1'b1, 8'h04, 1'b0, 3'b100, 3'b100); step();
        chk("prio_ctrl", 32'(ctrl_out), 32'h000203);
        chk("prio_valid", 32'(valid_out), 32'h3);
        drain();

        // async reset during BUSY (cnt=2), then stream 0x77
        drv(1'b1, 8'h44, 1'b1, 3'b000, 3'b000); step();
        drv(1'b0, 8'h00, 1'b0, 3'b000, 3'b000); step();
        #2 rst = 1'b0;
        #1 chk_zero("async_rst");
        m = '0;
        @(negedge clk);
        rst = 1'b1;
        drv(1'b1, 8'h77, 1'b0, 3'b000, 3'b000); step();
        drv(1'b0, 8'h00, 1'b0, 3'b000, 3'b000); step(); step();
        chk("post_rst", 32'({valid_out, ctrl_out}), 32'h4770000);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drv($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
                {$urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0},
                {$urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0});
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                #1 chk_zero("rand_rst");
                m = '0;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
